shift_serializer: RTL and testbench

- Parametrised successor to the fixed 8/4-bit shift registers: one WIDTH-generic register with the same four manual modes, plus an autonomous burst engine.
- Burst engine shifts a programmed number of bits (1..WIDTH) in a latched direction, with fill or rotate, and exposes the outgoing bit serially.
- Used as the serial front end for the lab's SPI-style links.
- Includes a start/busy/done handshake so a controller fires a burst and waits without counting clocks.

---
 rtl/shiftreg_pkg.sv | 8 +
 rtl/shift_serializer_if.sv | 21 ++
 rtl/shift_bit_counter.sv | 22 ++
 rtl/shift_serializer.sv | 69 ++++++
 tb/tb_shift_serializer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/shiftreg_pkg.sv
// shiftreg_pkg: shared mode codes, FSM state encoding and burst direction constants
// for the shift_serializer block.
package shiftreg_pkg;
   typedef enum logic [1:0] {HOLD = 2'b00, RIGHT = 2'b01, LEFT = 2'b10, PLOAD = 2'b11} mode_t;
   typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_t;
   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;
endpackage

// File: rtl/shift_serializer_if.sv
// shift_serializer_if: control/data bundle between a burst controller and shift_serializer.
//   master (controller): drives mode, parallelIn, serialIn, start, dir, rotate, nbits;
//                        observes parallelOut, serialOut, busy, done.
//   slave (serializer):  the mirror image.
interface shift_serializer_if #(parameter int WIDTH = 8, parameter int CNT_W = $clog2(WIDTH + 1));
   logic [1:0]       mode;
   logic [WIDTH-1:0] parallelIn;
   logic             serialIn;
   logic             start;
   logic             dir;
   logic             rotate;
   logic [CNT_W-1:0] nbits;
   logic [WIDTH-1:0] parallelOut;
   logic             serialOut;
   logic             busy;
   logic             done;
   modport master (output mode, parallelIn, serialIn, start, dir, rotate, nbits,
                   input  parallelOut, serialOut, busy, done);
   modport slave  (input  mode, parallelIn, serialIn, start, dir, rotate, nbits,
                   output parallelOut, serialOut, busy, done);
endinterface

// File: rtl/shift_bit_counter.sv
// shift_bit_counter: loadable down-counter for burst length, load value clamped to WIDTH.
//   clk, reset (async, active-high); load/load_val set the count; dec counts down,
//   never wrapping below zero; count is the current value; zero flags count == 0.
module shift_bit_counter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count,
   output logic             zero
);
   localparam logic [CNT_W-1:0] MAXC = CNT_W'(WIDTH);
   assign zero = count == '0;
   always_ff @(posedge clk or posedge reset)
      if (reset) count <= '0;
      else if (load) count <= load_val > MAXC ? MAXC : load_val;
      else if (dec && !zero) count <= count - CNT_W'(1);
endmodule

// File: rtl/shift_serializer.sv
// shift_serializer: WIDTH-bit shift register with manual modes and an autonomous burst engine.
//   clk, reset (async, active-high) plain ports; bus (slave modport) carries mode,
//   parallelIn, serialIn, start, dir, rotate, nbits in and parallelOut, serialOut,
//   busy, done out.
module shift_serializer
   import shiftreg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input logic            clk,
   input logic            reset,
   shift_serializer_if.slave bus
);
   state_t           state, state_n;
   logic [WIDTH-1:0] mem, mem_n;
   logic             dir_q, dir_n, rot_q, rot_n, load, dec, fill, zero;
   logic [CNT_W-1:0] count;

   shift_bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
      .clk(clk), .reset(reset), .load(load), .dec(dec),
      .load_val(bus.nbits), .count(count), .zero(zero)
   );

   // During a burst the outgoing bit follows the latched direction, otherwise the live input.
   assign bus.serialOut   = ((state == SHIFT) ? dir_q : bus.dir) == DIR_LEFT ? mem[WIDTH-1] : mem[0];
   assign bus.parallelOut = mem;
   assign bus.busy        = state == SHIFT;
   assign bus.done        = state == DONE;
   assign fill            = rot_q ? bus.serialOut : bus.serialIn;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         mem   <= '0;
         dir_q <= DIR_RIGHT;
         rot_q <= 1'b0;
      end else begin
         state <= state_n;
         mem   <= mem_n;
         dir_q <= dir_n;
         rot_q <= rot_n;
      end

   always_comb begin
      state_n = state;
      mem_n   = mem;
      dir_n   = dir_q;
      rot_n   = rot_q;
      load    = 1'b0;
      dec     = 1'b0;
      if (state == SHIFT) begin
         dec     = 1'b1;
         mem_n   = dir_q == DIR_LEFT ? {mem[WIDTH-2:0], fill} : {fill, mem[WIDTH-1:1]};
         state_n = (count == CNT_W'(1) || zero) ? DONE : SHIFT;
      end else if (bus.start) begin
         load    = 1'b1;
         dir_n   = bus.dir;
         rot_n   = bus.rotate;
         // A clamped length of zero equals nbits == 0, so skip straight to completion.
         state_n = bus.nbits == '0 ? DONE : SHIFT;
      end else begin
         state_n = IDLE;
         mem_n   = bus.mode == RIGHT ? {bus.serialIn, mem[WIDTH-1:1]} :
                   bus.mode == LEFT  ? {mem[WIDTH-2:0], bus.serialIn} :
                   bus.mode == PLOAD ? bus.parallelIn : mem;
      end
   end
endmodule

// File: tb/tb_shift_serializer.sv
// tb_shift_serializer: scoreboard bench for shift_serializer at WIDTH=8.
module tb_shift_serializer;
   import shiftreg_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int tests = 0;
   int fails = 0;
   logic [7:0] mdl;
   logic [7:0] sb[$];

   shift_serializer_if #(.WIDTH(8)) bus();
   shift_serializer #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.mode = HOLD; bus.parallelIn = 8'h00; bus.serialIn = 1'b0; bus.start = 1'b0;
      bus.dir = 1'b0; bus.rotate = 1'b0; bus.nbits = 4'd0;
      reset = 1'b1;
      tick();
      tests++;
      if (bus.parallelOut !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.serialOut !== 1'b0) begin
         fails++;
         $display("FAIL reset: po=%h busy=%b done=%b so=%b, want 00 0 0 0", bus.parallelOut, bus.busy, bus.done, bus.serialOut);
      end
      #2 reset = 1'b0;
      mdl = 8'h00;
   endtask

   task automatic manual(input string name, input logic [1:0] md, input logic [7:0] pin, input logic si, input logic [7:0] exp_v);
      bus.mode = md; bus.parallelIn = pin; bus.serialIn = si; bus.start = 1'b0;
      sb.push_back(exp_v);
      tick();
      bus.mode = HOLD;
      mdl = sb.pop_front();
      tests++;
      if (bus.parallelOut !== mdl) begin
         fails++;
         $display("FAIL %s: po=%h want %h", name, bus.parallelOut, mdl);
      end
   endtask

   task automatic test_legacy();
      manual("left", LEFT, 8'h00, 1'b1, 8'h01);
      manual("right", RIGHT, 8'h00, 1'b1, 8'h80);
      manual("hold1", HOLD, 8'hFF, 1'b1, 8'h80);
      manual("hold2", HOLD, 8'hFF, 1'b1, 8'h80);
      manual("hold3", HOLD, 8'hFF, 1'b1, 8'h80);
      manual("pload", PLOAD, 8'h3C, 1'b1, 8'h3C);
   endtask

   // Fires a burst: the expected final value is queued at start and popped at done.
   // hs keeps start high so the DONE cycle launches the next burst.
   task automatic burst(input string name, input logic d, input logic r, input logic [3:0] n,
                        input logic f, input logic [1:0] md, input logic [7:0] pin, input logic hs);
      int k;
      int bc;
      logic [7:0] e;
      logic [7:0] cur;
      k = (n > 4'd8) ? 8 : int'(n);
      e = mdl;
      for (int i = 0; i < k; i++) e = d ? {e[6:0], r ? e[7] : f} : {r ? e[0] : f, e[7:1]};
      sb.push_back(e);
      cur = mdl;
      bc = 0;
      bus.start = 1'b1; bus.dir = d; bus.rotate = r; bus.nbits = n; bus.serialIn = f;
      bus.mode = md; bus.parallelIn = pin;
      tick();
      if (!hs) bus.start = 1'b0;
      bus.dir = ~d;
      while (bus.busy === 1'b1 && bc < 20) begin
         tests++;
         if (bus.serialOut !== (d ? cur[7] : cur[0]) || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL %s_serial%0d: so=%b done=%b want so=%b done=0", name, bc, bus.serialOut, bus.done, d ? cur[7] : cur[0]);
         end
         cur = d ? {cur[6:0], r ? cur[7] : f} : {r ? cur[0] : f, cur[7:1]};
         bc++;
         tick();
      end
      bus.mode = HOLD;
      mdl = sb.pop_front();
      tests++;
      if (bc != k || bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.parallelOut !== mdl) begin
         fails++;
         $display("FAIL %s_end: busy_cycles=%0d done=%b busy=%b po=%h want %0d 1 0 %h", name, bc, bus.done, bus.busy, bus.parallelOut, k, mdl);
      end
      if (!hs) begin
         tick();
         tests++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.parallelOut !== mdl) begin
            fails++;
            $display("FAIL %s_after: done=%b busy=%b po=%h want 0 0 %h", name, bus.done, bus.busy, bus.parallelOut, mdl);
         end
      end
   endtask

   task automatic test_fill_burst();
      manual("pload_a5", PLOAD, 8'hA5, 1'b0, 8'hA5);
      burst("fill", DIR_RIGHT, 1'b0, 4'd3, 1'b0, HOLD, 8'h00, 1'b0);
      tests++;
      if (mdl !== 8'h14) begin
         fails++;
         $display("FAIL fill_value: model=%h want 14", mdl);
      end
   endtask

   task automatic test_rotate();
      manual("pload_a5r", PLOAD, 8'hA5, 1'b0, 8'hA5);
      burst("rotate", DIR_LEFT, 1'b1, 4'd4, 1'b0, HOLD, 8'h00, 1'b0);
      tests++;
      if (bus.parallelOut !== 8'h5A) begin
         fails++;
         $display("FAIL rotate_value: po=%h want 5a", bus.parallelOut);
      end
   endtask

   task automatic test_clamp_zero();
      manual("pload_a5c", PLOAD, 8'hA5, 1'b0, 8'hA5);
      burst("clamp", DIR_RIGHT, 1'b1, 4'd12, 1'b0, HOLD, 8'h00, 1'b0);
      burst("zero", DIR_LEFT, 1'b0, 4'd0, 1'b1, HOLD, 8'h00, 1'b0);
   endtask

   task automatic test_priority();
      manual("pload_c3", PLOAD, 8'hC3, 1'b0, 8'hC3);
      burst("prio", DIR_LEFT, 1'b0, 4'd5, 1'b1, PLOAD, 8'hFF, 1'b0);
   endtask

   task automatic test_back_to_back();
      manual("pload_96", PLOAD, 8'h96, 1'b0, 8'h96);
      burst("b2b_a", DIR_RIGHT, 1'b0, 4'd2, 1'b1, HOLD, 8'h00, 1'b1);
      burst("b2b_b", DIR_LEFT, 1'b1, 4'd3, 1'b0, HOLD, 8'h00, 1'b0);
   endtask

   task automatic test_reset_mid();
      bit seen_done;
      manual("pload_f0", PLOAD, 8'hF0, 1'b0, 8'hF0);
      bus.start = 1'b1; bus.dir = DIR_RIGHT; bus.rotate = 1'b0; bus.nbits = 4'd6; bus.serialIn = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      #2 reset = 1'b1;
      #1;
      tests++;
      if (bus.parallelOut !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: po=%h busy=%b done=%b want 00 0 0", bus.parallelOut, bus.busy, bus.done);
      end
      #2 reset = 1'b0;
      mdl = 8'h00;
      seen_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1'b1;
      end
      tests++;
      if (seen_done || bus.parallelOut !== 8'h00) begin
         fails++;
         $display("FAIL reset_mid_quiet: done_or_busy_seen=%b po=%h want 0 00", seen_done, bus.parallelOut);
      end
      manual("pload_5c", PLOAD, 8'h5C, 1'b0, 8'h5C);
      burst("post_reset", DIR_RIGHT, 1'b1, 4'd6, 1'b0, HOLD, 8'h00, 1'b0);
   endtask

   initial begin
      test_reset();
      test_legacy();
      test_fill_burst();
      test_rotate();
      test_clamp_zero();
      test_priority();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
